// File: rtl/packed_unpacked_arb.sv
// Round-robin burst arbiter: one requester at a time streams a fixed-length
// burst into a single registered output slot, then the block re-arbitrates.
module packed_unpacked_arb #(
    parameter int unsigned        NUM_REQ = 5,
    parameter int unsigned        DWIDTH  = 4,
    parameter logic [NUM_REQ-1:0] P_MASK  = '1,
    localparam int unsigned       IDW     = $clog2(NUM_REQ)
) (
    input  logic                           main_clk_i,
    input  logic                           main_rst_an_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][DWIDTH-1:0] data_i,
    input  logic [2:0]                     len_i [NUM_REQ-1:0],
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    output logic                           out_valid_o,
    output logic [DWIDTH-1:0]              out_data_o,
    output logic [IDW-1:0]                 out_id_o,
    output logic                           out_last_o,
    input  logic                           out_ready_i
);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             state;
    // Holds the index of the most recent grant; equals the active requester during a burst.
    logic [IDW-1:0]     ptr;
    logic [2:0]         cnt;

    logic [NUM_REQ-1:0] elig;
    logic               slot_free;
    logic               beat_ack;
    logic               hi_found;
    logic               lo_found;
    logic [IDW-1:0]     hi_idx;
    logic [IDW-1:0]     lo_idx;
    logic [IDW-1:0]     sel;
    logic               sel_valid;
    logic [NUM_REQ-1:0] sel_onehot;

    assign elig      = req_i & P_MASK;
    assign slot_free = ~out_valid_o | out_ready_i;

    // Cyclic search from ptr+1: lowest eligible index above ptr wins, else lowest at/below ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                if (IDW'(i) > ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        sel       = hi_found ? hi_idx : lo_idx;
        sel_valid = hi_found | lo_found;
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    // Beat acceptance: granted requester asserting req while the output slot can take a beat.
    always_comb begin
        ack_o = '0;
        if (state == ST_BURST && req_i[ptr] && slot_free) begin
            ack_o[ptr] = 1'b1;
        end
    end

    assign beat_ack = |ack_o;

    // Arbitration FSM, beat counter and output register.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            state       <= ST_IDLE;
            ptr         <= IDW'(NUM_REQ - 1);
            cnt         <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
            out_last_o  <= 1'b0;
        end else begin
            // A new beat overwrites the slot; otherwise a drain empties it.
            if (beat_ack) begin
                out_valid_o <= 1'b1;
                out_data_o  <= data_i[ptr];
                out_id_o    <= ptr;
                out_last_o  <= (cnt == 3'd0);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        grant_o <= sel_onehot;
                        busy_o  <= 1'b1;
                        ptr     <= sel;
                        cnt     <= len_i[sel];
                        state   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat_ack) begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packed_unpacked_arb.sv
// Directed bench for packed_unpacked_arb: per-cycle vector table plus
// multi-cycle sequences for back-pressure, request drop, reset and masking.
module tb_packed_unpacked_arb;

    localparam int unsigned NR = 5;
    localparam int unsigned DW = 4;
    localparam int unsigned IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NR-1:0]          req;
    logic [NR-1:0][DW-1:0]  data;
    logic [2:0]             len [NR-1:0];
    logic                   ready;

    logic [NR-1:0] ack, grant;
    logic          busy, ovalid, olast;
    logic [DW-1:0] odata;
    logic [IW-1:0] oid;

    logic [NR-1:0] m_ack, m_grant;
    logic          m_busy, m_ovalid, m_olast;
    logic [DW-1:0] m_odata;
    logic [IW-1:0] m_oid;

    packed_unpacked_arb #(.NUM_REQ(NR), .DWIDTH(DW)) u_dut (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .req_i(req), .data_i(data),
        .len_i(len), .ack_o(ack), .grant_o(grant), .busy_o(busy),
        .out_valid_o(ovalid), .out_data_o(odata), .out_id_o(oid),
        .out_last_o(olast), .out_ready_i(ready)
    );

    packed_unpacked_arb #(.NUM_REQ(NR), .DWIDTH(DW), .P_MASK(5'b10101)) u_dut_m (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .req_i(req), .data_i(data),
        .len_i(len), .ack_o(m_ack), .grant_o(m_grant), .busy_o(m_busy),
        .out_valid_o(m_ovalid), .out_data_o(m_odata), .out_id_o(m_oid),
        .out_last_o(m_olast), .out_ready_i(ready)
    );

    typedef struct {
        logic [NR-1:0] req;
        logic [2:0]    len;
        logic [3:0]    d;
        logic [NR-1:0] e_ack;
        logic [NR-1:0] e_grant;
        logic          e_busy;
        logic          e_valid;
        logic [IW-1:0] e_id;
        logic          e_last;
        logic [DW-1:0] e_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input logic [2:0] l);
        for (int r = 0; r < int'(NR); r++) len[r] = l;
    endtask

    // Row r carries d + r so a wrong-row select shows up in the data.
    task automatic set_data(input logic [3:0] d);
        for (int r = 0; r < int'(NR); r++) data[r] = 4'(int'(d) + r);
    endtask

    // One burst from requester r; either stalls the consumer (drop=0, starting
    // once 'at' beats were consumed) or drops req (drop=1, once 'at' beats were acked).
    task automatic burst_seq(input int r, input int blen, input bit drop, input int at, input int dur, input string tag);
        int sent, got, cyc, hold;
        bit fired, acked;
        logic [DW-1:0] held;
        logic [NR-1:0] oh;
        sent = 0; got = 0; cyc = 0; hold = 0; fired = 0; held = '0;
        oh = '0;
        oh[r] = 1'b1;
        set_len(3'(blen - 1));
        while (got < blen && cyc < 100) begin
            if (!fired && ((drop && sent == at) || (!drop && got == at))) begin
                fired = 1'b1;
                hold  = dur;
                held  = odata;
            end
            req   = (drop && hold > 0) ? '0 : ((sent < blen) ? oh : '0);
            ready = (!drop && hold > 0) ? 1'b0 : 1'b1;
            data  = '0;
            data[r] = 4'(sent);
            #1;
            if (hold > 0) begin
                chk({tag, "_hold_ack"}, 32'(ack), 0);
                if (drop) begin
                    chk({tag, "_hold_grant"}, 32'(grant), 32'(oh));
                end else begin
                    chk({tag, "_hold_data"}, 32'(odata), 32'(held));
                    chk({tag, "_hold_valid"}, 32'(ovalid), 1);
                end
            end
            acked = ack[r];
            if (ovalid && ready) begin
                chk({tag, "_beat_data"}, 32'(odata), 32'(got));
                chk({tag, "_beat_last"}, 32'(olast), 32'(got == blen - 1));
                chk({tag, "_beat_id"}, 32'(oid), 32'(r));
                got++;
            end
            @(posedge clk);
            #1;
            if (acked) sent++;
            if (hold > 0) hold--;
            cyc++;
        end
        chk({tag, "_beats_rx"}, 32'(got), 32'(blen));
        chk({tag, "_beats_tx"}, 32'(sent), 32'(blen));
        chk({tag, "_stall_seen"}, 32'(fired), 1);
        req = '0;
        tick();
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_grant_end"}, 32'(grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks, cyc, k, km;
        bit bad_mask_ack;
        int exp_main [6];
        int exp_mask [6];

        //                req       len   d     ack       grant     busy  valid id    last  data
        vecs[0]  = '{5'b00100, 3'd3, 4'd0, 5'b00000, 5'b00100, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0};
        vecs[1]  = '{5'b00100, 3'd3, 4'd1, 5'b00100, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b0, 4'd3};
        vecs[2]  = '{5'b00100, 3'd3, 4'd2, 5'b00100, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b0, 4'd4};
        vecs[3]  = '{5'b00100, 3'd3, 4'd3, 5'b00100, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b0, 4'd5};
        vecs[4]  = '{5'b00100, 3'd3, 4'd4, 5'b00100, 5'b00000, 1'b0, 1'b1, 3'd2, 1'b1, 4'd6};
        vecs[5]  = '{5'b00000, 3'd3, 4'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b1, 4'd6};
        vecs[6]  = '{5'b11111, 3'd0, 4'd0, 5'b00000, 5'b01000, 1'b1, 1'b0, 3'd2, 1'b1, 4'd6};
        vecs[7]  = '{5'b11111, 3'd0, 4'd5, 5'b01000, 5'b00000, 1'b0, 1'b1, 3'd3, 1'b1, 4'd8};
        vecs[8]  = '{5'b11111, 3'd0, 4'd6, 5'b00000, 5'b10000, 1'b1, 1'b0, 3'd3, 1'b1, 4'd8};
        vecs[9]  = '{5'b11111, 3'd0, 4'd7, 5'b10000, 5'b00000, 1'b0, 1'b1, 3'd4, 1'b1, 4'd11};
        vecs[10] = '{5'b11111, 3'd0, 4'd0, 5'b00000, 5'b00001, 1'b1, 1'b0, 3'd4, 1'b1, 4'd11};
        vecs[11] = '{5'b11111, 3'd0, 4'd1, 5'b00001, 5'b00000, 1'b0, 1'b1, 3'd0, 1'b1, 4'd1};
        vecs[12] = '{5'b11111, 3'd0, 4'd0, 5'b00000, 5'b00010, 1'b1, 1'b0, 3'd0, 1'b1, 4'd1};
        vecs[13] = '{5'b11111, 3'd0, 4'd2, 5'b00010, 5'b00000, 1'b0, 1'b1, 3'd1, 1'b1, 4'd3};
        vecs[14] = '{5'b11111, 3'd0, 4'd0, 5'b00000, 5'b00100, 1'b1, 1'b0, 3'd1, 1'b1, 4'd3};
        vecs[15] = '{5'b11111, 3'd0, 4'd3, 5'b00100, 5'b00000, 1'b0, 1'b1, 3'd2, 1'b1, 4'd5};
        vecs[16] = '{5'b00000, 3'd0, 4'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b1, 4'd5};

        exp_main = '{0, 1, 2, 3, 4, 0};
        exp_mask = '{0, 2, 4, 0, 2, 4};

        rst_n = 1'b0;
        req   = '0;
        ready = 1'b1;
        data  = '0;
        set_len(3'd0);
        tick();
        tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(ovalid), 0);
        chk("rst_data", 32'(odata), 0);
        chk("rst_id", 32'(oid), 0);
        chk("rst_last", 32'(olast), 0);

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            req = vecs[i].req;
            set_len(vecs[i].len);
            set_data(vecs[i].d);
            #1;
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_valid", i), 32'(ovalid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_id", i), 32'(oid), 32'(vecs[i].e_id));
            chk($sformatf("vec%0d_last", i), 32'(olast), 32'(vecs[i].e_last));
            chk($sformatf("vec%0d_data", i), 32'(odata), 32'(vecs[i].e_data));
        end

        burst_seq(0, 8, 1'b0, 2, 3, "bp");
        burst_seq(1, 5, 1'b1, 2, 2, "drop");

        // Reset in the middle of a 4-beat burst from requester 3.
        req   = 5'b01000;
        ready = 1'b1;
        set_len(3'd3);
        set_data(4'd0);
        acks = 0;
        cyc  = 0;
        while (acks < 2 && cyc < 20) begin
            #1;
            if (ack[3]) acks++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mid_acks", 32'(acks), 2);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("mrst_ack", 32'(ack), 0);
        chk("mrst_grant", 32'(grant), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_valid", 32'(ovalid), 0);
        chk("mrst_data", 32'(odata), 0);
        chk("mrst_id", 32'(oid), 0);
        chk("mrst_last", 32'(olast), 0);

        // All requesting with single-beat bursts: unmasked and masked grant order.
        rst_n = 1'b1;
        req   = 5'b11111;
        set_len(3'd0);
        k = 0;
        km = 0;
        bad_mask_ack = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if ((m_ack & 5'b01010) != 5'b00000) bad_mask_ack = 1'b1;
            if (grant != '0 && k < 6) begin
                chk($sformatf("rr_grant%0d", k), 32'(grant), 32'(5'b00001 << exp_main[k]));
                k++;
            end
            if (m_grant != '0 && km < 6) begin
                chk($sformatf("mask_grant%0d", km), 32'(m_grant), 32'(5'b00001 << exp_mask[km]));
                km++;
            end
        end
        chk("rr_count", 32'(k), 6);
        chk("mask_count", 32'(km), 6);
        chk("mask_no_ack_1_3", 32'(bad_mask_ack), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
